// File: rtl/reg_file_rename_pkg.sv
// reg_file_rename_pkg: shared core widths and typedefs for register file, ROB and reservation stations
package reg_file_rename_pkg;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam int AW = $clog2(NUM_REGS);
  localparam int TAG_W = 4;
  localparam int NUM_RD = 2;
  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [TAG_W-1:0] rob_tag_t;
  typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/reg_file_rename_read_port.sv
// rf_read_port: one read port with x0 handling and commit bypass / busy override
module rf_read_port import reg_file_rename_pkg::*; #(
  parameter int XLEN = reg_file_rename_pkg::XLEN,
  parameter int AW = reg_file_rename_pkg::AW,
  parameter int TAG_W = reg_file_rename_pkg::TAG_W
) (
  input  logic [AW-1:0]    addr,
  input  logic [XLEN-1:0]  st_data,
  input  logic             st_busy,
  input  logic [TAG_W-1:0] st_tag,
  input  logic             commit_en,
  input  logic [AW-1:0]    commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_data,
  output logic [XLEN-1:0]  data,
  output logic             busy,
  output logic [TAG_W-1:0] tag
);
  logic nz, byp;
  // x0 reads as constant zero; a same-cycle commit to the address forwards its data
  always_comb begin
    nz = addr != '0;
    byp = nz && commit_en && commit_rd == addr;
    data = !nz ? '0 : byp ? commit_data : st_data;
    busy = nz && st_busy && !(byp && st_tag == commit_tag);
    tag = nz ? st_tag : '0;
  end
endmodule

// File: rtl/reg_file_rename.sv
// reg_file_rename: architectural register file with per-register busy bit and ROB tag
module reg_file_rename import reg_file_rename_pkg::*; #(
  parameter int XLEN = reg_file_rename_pkg::XLEN,
  parameter int NUM_REGS = reg_file_rename_pkg::NUM_REGS,
  parameter int TAG_W = reg_file_rename_pkg::TAG_W,
  parameter int NUM_RD = reg_file_rename_pkg::NUM_RD,
  parameter int AW = $clog2(NUM_REGS)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic                   rename_en,
  input  logic [AW-1:0]          rename_rd,
  input  logic [TAG_W-1:0]       rename_tag,
  input  logic                   commit_en,
  input  logic [AW-1:0]          commit_rd,
  input  logic [TAG_W-1:0]       commit_tag,
  input  logic [XLEN-1:0]        commit_data,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  output logic [NUM_RD*TAG_W-1:0] rd_tag,
  input  logic [AW-1:0]          dbg_sel,
  output logic [XLEN-1:0]        dbg_data
);
  logic [XLEN-1:0]  regs [NUM_REGS];
  logic [TAG_W-1:0] tags [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic commit_vis;
  assign commit_vis = commit_en && !rst_in;
  assign dbg_data = regs[dbg_sel];
  // committed values land in the file; x0 is never written
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (rdy_in && commit_en && commit_rd != '0) regs[commit_rd] <= commit_data;
  end
  // rename sets busy/tag; flush clears all busy; matching commit clears busy unless renamed again
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy <= '0;
      for (int i = 0; i < NUM_REGS; i++) tags[i] <= '0;
    end else if (rdy_in) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (flush_in) busy[i] <= 1'b0;
        else if (rename_en && rename_rd == AW'(i)) begin
          busy[i] <= 1'b1;
          tags[i] <= rename_tag;
        end else if (commit_en && commit_rd == AW'(i) && busy[i] && tags[i] == commit_tag) busy[i] <= 1'b0;
      end
    end
  end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[g*AW +: AW];
    rf_read_port #(.XLEN(XLEN), .AW(AW), .TAG_W(TAG_W)) u_port (
      .addr(a),
      .st_data(regs[a]),
      .st_busy(busy[a]),
      .st_tag(tags[a]),
      .commit_en(commit_vis),
      .commit_rd(commit_rd),
      .commit_tag(commit_tag),
      .commit_data(commit_data),
      .data(rd_data[g*XLEN +: XLEN]),
      .busy(rd_busy[g]),
      .tag(rd_tag[g*TAG_W +: TAG_W])
    );
  end
endmodule

// File: tb/tb_reg_file_rename.sv
// tb_reg_file_rename: directed self-checking bench for reg_file_rename
module tb_reg_file_rename;
  import reg_file_rename_pkg::*;
  logic clk_in = 1'b0, rst_in, rdy_in, flush_in, rename_en, commit_en;
  reg_addr_t rename_rd, commit_rd, dbg_sel;
  rob_tag_t rename_tag, commit_tag;
  word_t commit_data, dbg_data;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0] rd_busy;
  logic [NUM_RD*TAG_W-1:0] rd_tag;
  int checks = 0, errors = 0;
  word_t d0, d1;
  rob_tag_t t0, t1;
  always #5 clk_in = ~clk_in;
  reg_file_rename dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag), .commit_data(commit_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );
  always_comb begin
    d0 = rd_data[0 +: XLEN];
    d1 = rd_data[XLEN +: XLEN];
    t0 = rd_tag[0 +: TAG_W];
    t1 = rd_tag[TAG_W +: TAG_W];
  end
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic idle();
    flush_in = 0; rename_en = 0; commit_en = 0;
    rename_rd = '0; rename_tag = '0; commit_rd = '0; commit_tag = '0; commit_data = '0;
  endtask
  task automatic rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
    #1;
  endtask
  task automatic test_reset();
    rst_in = 1; rdy_in = 1; idle(); dbg_sel = 5'd1;
    commit_en = 1; commit_rd = 5'd1; commit_data = 32'hFFFF_FFFF;
    rd(1, 2);
    checks++; if (d0 !== '0 || rd_busy !== '0 || rd_tag !== '0 || dbg_data !== '0) begin errors++; $display("FAIL reset_outputs d0=%h busy=%b tag=%h dbg=%h want all 0", d0, rd_busy, rd_tag, dbg_data); end
    tick(); idle(); #1; rst_in = 0; tick();
    for (int i = 1; i < 32; i++) begin
      rd(i, 32 - i);
      checks++; if (d0 !== '0 || d1 !== '0 || rd_busy !== 2'b00) begin errors++; $display("FAIL reset_read x%0d d0=%h d1=%h busy=%b want 0", i, d0, d1, rd_busy); end
    end
    rename_en = 1; rename_rd = '0; rename_tag = 4'd3;
    commit_en = 1; commit_rd = '0; commit_tag = 4'd3; commit_data = 32'hDEAD_BEEF;
    rd(0, 0);
    checks++; if (d0 !== '0 || rd_busy !== 2'b00) begin errors++; $display("FAIL x0_bypass d0=%h busy=%b want 0/00", d0, rd_busy); end
    tick(); idle(); dbg_sel = '0; rd(0, 0);
    checks++; if (d1 !== '0 || rd_busy !== 2'b00 || t0 !== '0 || dbg_data !== '0) begin errors++; $display("FAIL x0_write d=%h busy=%b tag=%h dbg=%h want 0", d1, rd_busy, t0, dbg_data); end
  endtask
  task automatic test_rename_commit();
    rename_en = 1; rename_rd = 5'd5; rename_tag = 4'd2;
    rd(5, 5);
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL rename_same_cycle busy=%b want 00", rd_busy); end
    tick(); idle(); rd(5, 5);
    checks++; if (rd_busy !== 2'b11 || t0 !== 4'd2 || t1 !== 4'd2) begin errors++; $display("FAIL rename_x5 busy=%b tag=%h want 11/2", rd_busy, t0); end
    commit_en = 1; commit_rd = 5'd5; commit_tag = 4'd2; commit_data = 32'h1234;
    rd(5, 5);
    checks++; if (d0 !== 32'h1234 || d1 !== 32'h1234 || rd_busy !== 2'b00) begin errors++; $display("FAIL commit_bypass d0=%h d1=%h busy=%b want 1234/00", d0, d1, rd_busy); end
    tick(); idle(); dbg_sel = 5'd5; rd(5, 5);
    checks++; if (d0 !== 32'h1234 || rd_busy !== 2'b00 || dbg_data !== 32'h1234) begin errors++; $display("FAIL commit_x5 d=%h busy=%b dbg=%h want 1234/00/1234", d0, rd_busy, dbg_data); end
  endtask
  task automatic test_stale_commit();
    rename_en = 1; rename_rd = 5'd7; rename_tag = 4'd1; tick();
    rename_tag = 4'd4; tick(); idle();
    commit_en = 1; commit_rd = 5'd7; commit_tag = 4'd1; commit_data = 32'hAA;
    rd(7, 1);
    checks++; if (d0 !== 32'hAA || rd_busy[0] !== 1'b1 || t0 !== 4'd4) begin errors++; $display("FAIL stale_bypass d=%h busy=%b tag=%h want aa/1/4", d0, rd_busy[0], t0); end
    tick(); idle(); rd(1, 7);
    checks++; if (d1 !== 32'hAA || rd_busy !== 2'b10 || t1 !== 4'd4) begin errors++; $display("FAIL stale_commit d=%h busy=%b tag=%h want aa/10/4", d1, rd_busy, t1); end
    commit_en = 1; commit_rd = 5'd7; commit_tag = 4'd4; commit_data = 32'hBB;
    rd(7, 7);
    checks++; if (d0 !== 32'hBB || rd_busy !== 2'b00) begin errors++; $display("FAIL match_bypass d=%h busy=%b want bb/00", d0, rd_busy); end
    tick(); idle(); rd(7, 7);
    checks++; if (d0 !== 32'hBB || rd_busy !== 2'b00) begin errors++; $display("FAIL match_commit d=%h busy=%b want bb/00", d0, rd_busy); end
  endtask
  task automatic test_back_to_back();
    commit_en = 1; commit_rd = 5'd9; commit_tag = 4'd3; commit_data = 32'h55;
    rename_en = 1; rename_rd = 5'd9; rename_tag = 4'd6;
    tick(); idle(); rd(9, 9);
    checks++; if (d0 !== 32'h55 || rd_busy !== 2'b11 || t0 !== 4'd6) begin errors++; $display("FAIL rename_wins d=%h busy=%b tag=%h want 55/11/6", d0, rd_busy, t0); end
  endtask
  task automatic test_flush();
    rename_en = 1;
    rename_rd = 5'd2; rename_tag = 4'd1; tick();
    rename_rd = 5'd3; rename_tag = 4'd2; tick();
    rename_rd = 5'd4; rename_tag = 4'd3; tick(); idle(); rd(2, 4);
    checks++; if (rd_busy !== 2'b11 || t0 !== 4'd1 || t1 !== 4'd3) begin errors++; $display("FAIL pre_flush busy=%b tags=%h/%h want 11/1/3", rd_busy, t0, t1); end
    flush_in = 1; commit_en = 1; commit_rd = 5'd2; commit_tag = 4'd1; commit_data = 32'h77;
    rename_en = 1; rename_rd = 5'd6; rename_tag = 4'd5;
    tick(); idle(); rd(2, 3);
    checks++; if (d0 !== 32'h77 || rd_busy !== 2'b00) begin errors++; $display("FAIL flush_x2_x3 d=%h busy=%b want 77/00", d0, rd_busy); end
    rd(4, 6);
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL flush_x4_x6 busy=%b want 00", rd_busy); end
    rd(9, 9);
    checks++; if (rd_busy !== 2'b00 || d0 !== 32'h55) begin errors++; $display("FAIL flush_x9 busy=%b d=%h want 00/55", rd_busy, d0); end
  endtask
  task automatic test_ready();
    rdy_in = 0; dbg_sel = 5'd10;
    commit_en = 1; commit_rd = 5'd10; commit_tag = 4'd0; commit_data = 32'h99;
    rename_en = 1; rename_rd = 5'd11; rename_tag = 4'd7;
    tick(); tick(); rd(10, 11);
    checks++; if (dbg_data !== '0 || d0 !== 32'h99 || rd_busy !== 2'b00) begin errors++; $display("FAIL rdy_low dbg=%h d=%h busy=%b want 0/99/00", dbg_data, d0, rd_busy); end
    rdy_in = 1; tick(); idle(); rd(10, 11);
    checks++; if (dbg_data !== 32'h99 || d0 !== 32'h99 || rd_busy !== 2'b10 || t1 !== 4'd7) begin errors++; $display("FAIL rdy_high dbg=%h d=%h busy=%b tag=%h want 99/99/10/7", dbg_data, d0, rd_busy, t1); end
  endtask
  task automatic test_reset_mid();
    #2; rst_in = 1; rd(10, 11);
    checks++; if (d0 !== '0 || rd_busy !== 2'b00 || t1 !== '0 || dbg_data !== '0) begin errors++; $display("FAIL mid_reset d=%h busy=%b tag=%h dbg=%h want 0", d0, rd_busy, t1, dbg_data); end
    tick(); rst_in = 0; tick(); rd(5, 7);
    checks++; if (d0 !== '0 || d1 !== '0 || rd_busy !== 2'b00) begin errors++; $display("FAIL after_reset d0=%h d1=%h busy=%b want 0", d0, d1, rd_busy); end
  endtask
  initial begin
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_back_to_back();
    test_flush();
    test_ready();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
